instr_issue: RTL
================

Name: instr_issue

Overview:
- Initiator side of the controller's s/w start/wait handshake.
- Holds a small program buffer of 16-bit instruction words, loaded through a write port.
- On `run`, presents one instruction at a time on `instr`, pulses `s`, and waits for the controller to return to its wait state (`w=1`) before advancing the PC.
- Sits between a testbench/loader and the controller FSM. `instr[15:13]` drives opcode and `instr[12:11]` drives op.

Parameters:
- DEPTH, 16, number of program buffer entries
- AW, 4, address/PC width; DEPTH = 2**AW
- HALT_OP, 3'b111, opcode that terminates the program

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-low reset
- load_en  in  1  write load_data into buffer[load_addr]; honoured only in IDLE or DONE
- load_addr  in  AW  buffer write address
- load_data  in  16  instruction word
- run  in  1  start execution from PC 0; honoured only in IDLE or DONE
- w  in  1  controller wait flag; 1 = controller idle
- s  out  1  start pulse to controller
- instr  out  16  current instruction; stable from ISSUE until w returns
- pc  out  AW  index of the current instruction
- busy  out  1  high in ISSUE and EXEC
- done  out  1  high in DONE
- issued  out  8  count of instructions completed, saturating at 255
- timeout  out  1  watchdog flag (macro-dependent)

Behaviour:
- Reset (reset==0 at a posedge):
  - state=IDLE; s=0, pc=0, instr=0, busy=0, done=0, issued=0, timeout=0.
  - Buffer contents are not cleared.
  - Reset during ISSUE or EXEC aborts immediately; the controller is reset by the same line.
- States: IDLE, FETCH, ISSUE, EXEC, DONE.
- IDLE/DONE:
  - load_en writes the buffer.
  - run=1 sets pc=0, clears issued and timeout, and goes to FETCH.
  - If load_en and run are both high in the same cycle, the write lands first; FETCH reads the new data one cycle later.
- FETCH:
  - instr <= buffer[pc].
  - If buffer[pc][15:13]==HALT_OP, go to DONE (the halt word is not issued and not counted).
  - Otherwise go to ISSUE.
- ISSUE:
  - s=1 for exactly one cycle; the controller leaves its wait state on this edge.
  - Go to EXEC unconditionally.
- EXEC:
  - s=0. Wait for w==1; the controller forces w=0 whenever it is out of its wait state.
  - On w==1: issued++ (saturating).
  - If pc==DEPTH-1, go to DONE with pc held (no wrap). Otherwise pc++ and go to FETCH.
- Latency: minimum 3 cycles of issue overhead per instruction (FETCH, ISSUE, the EXEC cycle that sees w); total per instruction is controller latency plus 2.
- w already high in the first EXEC cycle is treated as completion; this covers a zero-latency or decode-default controller.
- load_en or run asserted in FETCH/ISSUE/EXEC is ignored with no side effects.
- instr holds its value through DONE.

Optional Feature:
- Macro: INSTR_ISSUE_WATCHDOG_EN.
- Defined:
  - A 6-bit counter clears on entry to EXEC and increments each EXEC cycle with w==0.
  - At 63, set timeout=1, go to DONE, and do not increment issued.
  - timeout clears on reset or run.
- Undefined:
  - No counter. timeout is tied to 0. EXEC waits indefinitely.

Decomposition:
- Shared package instr_issue_pkg holds:
  - state encoding constants (ST_IDLE..ST_DONE, 3 bits)
  - HALT_OP
  - instruction field slice positions (OPC_HI=15, OPC_LO=13, OP_HI=12, OP_LO=11)
  - watchdog limit (6'd63)
- One sub-module, instr_buf: DEPTH x 16 register file with synchronous write and combinational read, no reset.
- The FSM, PC, and counter stay in the top module.

Test Plan:
- Load [0]=16'hA000 (ADD), [1]=16'hE000; run; model controller returns w=1 after 4 cycles -> s pulses once, instr=16'hA000 during EXEC, done=1, pc=1, issued=1.
- Fill all 16 entries with 16'hC000, no halt; run -> 16 s pulses, pc stops at 15 (no wrap to 0), issued=16, done=1.
- In EXEC, assert load_en (addr 0, data 16'hFFFF) and run -> buffer[0] unchanged, pc unchanged; reread after DONE shows original word.
- Drive reset=0 for one cycle mid-EXEC -> next cycle s=0, pc=0, busy=0, issued=0, state IDLE; buffer[0] retains its value.
- [0]=16'hE000; run -> FETCH goes directly to DONE, no s pulse, issued=0.
- With INSTR_ISSUE_WATCHDOG_EN, hold w=0 after issue -> timeout=1 after 63 EXEC cycles, done=1, issued=0; without the macro, busy stays high and timeout=0.

Source files
------------

// File: rtl/instr_issue_pkg.sv
// Shared constants for the instruction issue unit.
// Watchdog option: INSTR_ISSUE_WATCHDOG_EN.
package instr_issue_pkg;

   localparam int DEPTH_DEF = 16;
   localparam int AW_DEF    = 4;

   localparam logic [2:0] ST_IDLE  = 3'd0;
   localparam logic [2:0] ST_FETCH = 3'd1;
   localparam logic [2:0] ST_ISSUE = 3'd2;
   localparam logic [2:0] ST_EXEC  = 3'd3;
   localparam logic [2:0] ST_DONE  = 3'd4;

   localparam logic [2:0] HALT_OP = 3'b111;

   localparam int OPC_HI = 15;
   localparam int OPC_LO = 13;
   localparam int OP_HI  = 12;
   localparam int OP_LO  = 11;

   localparam logic [5:0] WD_LIMIT = 6'd63;

   function automatic logic is_halt(input logic [15:0] word);
      return word[OPC_HI:OPC_LO] == HALT_OP;
   endfunction

endpackage

// File: rtl/instr_issue_if.sv
// Start/wait handshake between the issue unit and the controller.
// master = issue unit, slave = controller.
interface instr_issue_if;

   logic        s;
   logic        w;
   logic [15:0] instr;

   modport master (output s, output instr, input w);
   modport slave  (input s, input instr, output w);

endinterface

// File: rtl/instr_issue_buf.sv
// Program buffer: register file, synchronous write, combinational read.
// Contents are deliberately not reset.
module instr_buf #(
   parameter int AW    = 4,
   parameter int DEPTH = 2**AW
) (
   input  logic          clk,
   input  logic          we,
   input  logic [AW-1:0] waddr,
   input  logic [15:0]   wdata,
   input  logic [AW-1:0] raddr,
   output logic [15:0]   rdata
);

   logic [15:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/instr_issue.sv
// Instruction issue unit: steps a small program through the s/w handshake.
// Watchdog option: INSTR_ISSUE_WATCHDOG_EN.
module instr_issue
   import instr_issue_pkg::*;
#(
   parameter int AW    = AW_DEF,
   parameter int DEPTH = 2**AW
) (
   input  logic           clk,
   input  logic           reset,
   input  logic           load_en,
   input  logic [AW-1:0]  load_addr,
   input  logic [15:0]    load_data,
   input  logic           run,
   instr_issue_if.master  ctl,
   output logic [AW-1:0]  pc,
   output logic           busy,
   output logic           done,
   output logic [7:0]     issued,
   output logic           timeout
);

   logic [2:0]  state;
   logic [15:0] instr_q;
   logic [15:0] rdata;
   logic        idle_done;
   logic        start;
   logic        wd_hit;

   assign idle_done = (state == ST_IDLE) || (state == ST_DONE);
   assign start     = idle_done && run;

   instr_buf #(.AW(AW), .DEPTH(DEPTH)) u_buf (
      .clk   (clk),
      .we    (idle_done && load_en),
      .waddr (load_addr),
      .wdata (load_data),
      .raddr (pc),
      .rdata (rdata)
   );

   assign ctl.s     = (state == ST_ISSUE);
   assign ctl.instr = instr_q;
   assign busy      = (state == ST_ISSUE) || (state == ST_EXEC);
   assign done      = (state == ST_DONE);

`ifdef INSTR_ISSUE_WATCHDOG_EN
   logic [5:0] wd_cnt;
   logic       to_q;

   assign wd_hit  = (state == ST_EXEC) && !ctl.w &&
                    (wd_cnt == WD_LIMIT - 6'd1);
   assign timeout = to_q;

   // Counts EXEC cycles spent waiting; the 63rd one trips.
   always_ff @(posedge clk) begin
      if (!reset) begin
         wd_cnt <= '0;
         to_q   <= 1'b0;
      end else begin
         if (state == ST_ISSUE)
            wd_cnt <= '0;
         else if ((state == ST_EXEC) && !ctl.w)
            wd_cnt <= wd_cnt + 6'd1;
         if (start)
            to_q <= 1'b0;
         else if (wd_hit)
            to_q <= 1'b1;
      end
   end
`else
   assign wd_hit  = 1'b0;
   assign timeout = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (!reset) begin
         state   <= ST_IDLE;
         pc      <= '0;
         instr_q <= '0;
         issued  <= '0;
      end else begin
         case (state)
            ST_IDLE, ST_DONE: begin
               if (run) begin
                  pc     <= '0;
                  issued <= '0;
                  state  <= ST_FETCH;
               end
            end
            ST_FETCH: begin
               instr_q <= rdata;
               state   <= is_halt(rdata) ? ST_DONE : ST_ISSUE;
            end
            ST_ISSUE: begin
               state <= ST_EXEC;
            end
            ST_EXEC: begin
               if (ctl.w) begin
                  if (issued != 8'hFF) issued <= issued + 8'd1;
                  if (pc == AW'(DEPTH - 1)) begin
                     state <= ST_DONE;
                  end else begin
                     pc    <= pc + AW'(1);
                     state <= ST_FETCH;
                  end
               end else if (wd_hit) begin
                  state <= ST_DONE;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule
